// File: rtl/first_system_pkg.sv
// first_system shared defaults and output truth table.
// Counter feature: FIRST_SYSTEM_CNT_EN.
package first_system_pkg;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int CNT_W_DEF       = 8;
   localparam int RST_STAGES      = 2;

   typedef logic [1:0] svec_t;

   // Indexed by {s1, s2}.
   localparam logic [3:0] TT_AND = 4'b1000;
   localparam logic [3:0] TT_OR  = 4'b1110;

endpackage

// File: rtl/fs_sync.sv
// Generic flop-chain synchronizer, async active-low clear.
// Build option FIRST_SYSTEM_CNT_EN does not affect this file.
module fs_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/first_system.sv
// Two-input synchronizer with registered AND/OR outputs.
// Define FIRST_SYSTEM_CNT_EN to add the chg_cnt change counter.
module first_system
   import first_system_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in1,
   input  logic             in2,
   output logic             out1,
   output logic             out2
`ifdef FIRST_SYSTEM_CNT_EN
   ,
   output logic [CNT_W-1:0] chg_cnt
`endif
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("SYNC_STAGES must be 2..4");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   logic rst_sync_n;
   logic s1;
   logic s2;

   // Release of rst_n is retimed; assertion still clears at once.
   fs_sync #(.STAGES(RST_STAGES)) u_rst (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (1'b1),
      .q     (rst_sync_n)
   );

   fs_sync #(.STAGES(SYNC_STAGES)) u_s1 (
      .clk   (clk),
      .rst_n (rst_sync_n),
      .d     (in1),
      .q     (s1)
   );

   fs_sync #(.STAGES(SYNC_STAGES)) u_s2 (
      .clk   (clk),
      .rst_n (rst_sync_n),
      .d     (in2),
      .q     (s2)
   );

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         out1 <= 1'b0;
         out2 <= 1'b0;
      end else begin
         out1 <= s1 & s2;
         out2 <= s1 | s2;
      end
   end

`ifdef FIRST_SYSTEM_CNT_EN
   svec_t                s_prev;
   logic [SYNC_STAGES:0] warm;
   logic                 primed;

   // s_prev only holds a real sample once the chain has refilled.
   assign primed = warm[SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         s_prev  <= '0;
         warm    <= '0;
         chg_cnt <= '0;
      end else begin
         s_prev <= {s1, s2};
         warm   <= {warm[SYNC_STAGES-1:0], 1'b1};
         if (primed && ({s1, s2} != s_prev) && (chg_cnt != '1)) begin
            chg_cnt <= chg_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_first_system.sv
// Directed bench for first_system; counter checks only
// when FIRST_SYSTEM_CNT_EN is defined.
module tb_first_system;
   import first_system_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic in1;
   logic in2;
   logic out1;
   logic out2;
   logic out1_b;
   logic out2_b;
`ifdef FIRST_SYSTEM_CNT_EN
   logic [7:0] cnt;
   logic [1:0] cnt_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   first_system dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in1     (in1),
      .in2     (in2),
      .out1    (out1),
      .out2    (out2)
`ifdef FIRST_SYSTEM_CNT_EN
      ,
      .chg_cnt (cnt)
`endif
   );

   first_system #(.CNT_W(2)) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .in1     (in1),
      .in2     (in2),
      .out1    (out1_b),
      .out2    (out2_b)
`ifdef FIRST_SYSTEM_CNT_EN
      ,
      .chg_cnt (cnt_b)
`endif
   );

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a, input logic b);
      @(negedge clk);
      in1 = a;
      in2 = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in1   = 1'b0;
      in2   = 1'b0;
      edges(3);
      @(negedge clk);
      rst_n = 1'b1;
      edges(10);
   endtask

   // Apply v, confirm old outputs after 2 edges and new after 3.
   task automatic step_vec(input string tag,
                           input logic [1:0] v,
                           input logic [1:0] prev_exp,
                           input logic [1:0] new_exp,
                           input int hold);
      drive(v[1], v[0]);
      edges(2);
      chk({tag, "_e2"}, {30'd0, out1, out2}, {30'd0, prev_exp});
      edges(1);
      chk({tag, "_e3"}, {30'd0, out1, out2}, {30'd0, new_exp});
      edges(hold - 3);
   endtask

   logic [3:0] tand;
   logic [3:0] tor;
   logic [1:0] walk [5];
   logic [1:0] prev;
   logic [1:0] expv;

   initial begin
      tand = TT_AND;
      tor  = TT_OR;
      walk[0] = 2'b00;
      walk[1] = 2'b01;
      walk[2] = 2'b10;
      walk[3] = 2'b11;
      walk[4] = 2'b00;

      rst_n = 1'b0;
      in1   = 1'b1;
      in2   = 1'b1;
      #1;
      chk("rst_out1", {31'd0, out1}, 32'd0);
      chk("rst_out2", {31'd0, out2}, 32'd0);
`ifdef FIRST_SYSTEM_CNT_EN
      chk("rst_cnt", {24'd0, cnt}, 32'd0);
`endif

      edges(3);
      @(negedge clk);
      in1   = 1'b0;
      in2   = 1'b0;
      rst_n = 1'b1;
      edges(10);
      chk("idle_out", {30'd0, out1, out2}, 32'd0);

      prev = 2'b00;
      for (int i = 0; i < 5; i++) begin
         expv = {tand[walk[i]], tor[walk[i]]};
         step_vec($sformatf("walk%0d", i), walk[i], prev, expv, 10);
         prev = expv;
      end
`ifdef FIRST_SYSTEM_CNT_EN
      chk("walk_cnt", {24'd0, cnt}, 32'd4);
`endif

      step_vec("simul", 2'b11, 2'b00, 2'b11, 10);
`ifdef FIRST_SYSTEM_CNT_EN
      chk("simul_cnt", {24'd0, cnt}, 32'd5);
`endif
      step_vec("back00", 2'b00, 2'b11, 2'b00, 10);

      drive(1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out2", {31'd0, out2}, 32'd0);
`ifdef FIRST_SYSTEM_CNT_EN
      chk("mid_rst_cnt", {24'd0, cnt}, 32'd0);
`endif
      edges(3);
      chk("mid_hold_out2", {31'd0, out2}, 32'd0);
      @(negedge clk);
      in1   = 1'b0;
      rst_n = 1'b1;
      edges(10);
      chk("mid_rel_out2", {31'd0, out2}, 32'd0);
`ifdef FIRST_SYSTEM_CNT_EN
      chk("mid_rel_cnt", {24'd0, cnt}, 32'd0);
`endif
      step_vec("mid_next", 2'b10, 2'b00, 2'b01, 10);
`ifdef FIRST_SYSTEM_CNT_EN
      chk("mid_next_cnt", {24'd0, cnt}, 32'd1);
`endif

      do_reset();
`ifdef FIRST_SYSTEM_CNT_EN
      chk("sat_start", {30'd0, cnt_b}, 32'd0);
`endif
      for (int t = 1; t <= 6; t++) begin
         drive(t[0], 1'b0);
         edges(5);
         chk($sformatf("sat_out2_%0d", t), {31'd0, out2_b}, {31'd0, t[0]});
`ifdef FIRST_SYSTEM_CNT_EN
         chk($sformatf("sat_cnt_%0d", t), {30'd0, cnt_b},
             (t < 3) ? t : 32'd3);
`endif
      end
`ifdef FIRST_SYSTEM_CNT_EN
      chk("sat_wide_cnt", {24'd0, cnt}, 32'd6);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/first_system.md
FIRST_SYSTEM -- requirements
Module: first_system

Interface
REQ-001 Parameter SYNC_STAGES, default 2, shall set the number of input synchronizer flops per input; legal range 2..4.
REQ-002 Parameter CNT_W, default 8, shall set the width of the change counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in1  input  1  asynchronous operand A.
REQ-006 in2  input  1  asynchronous operand B.
REQ-007 out1  output  1  registered AND of the synchronized operands.
REQ-008 out2  output  1  registered OR of the synchronized operands.
REQ-009 chg_cnt  output  CNT_W  number of changes of the synchronized input vector; exists only when FIRST_SYSTEM_CNT_EN is defined.

Function
REQ-010 in1 and in2 shall each pass through an independent SYNC_STAGES-deep flop chain; the last stages form the vector s = {s1, s2}.
REQ-011 out1 shall register s1 AND s2 on each rising edge.
REQ-012 out2 shall register s1 OR s2 on each rising edge.
REQ-013 Latency from a stable input change to the outputs shall be exactly SYNC_STAGES+1 rising edges; no combinational path from in1 or in2 to any output.
REQ-014 Simultaneous changes of in1 and in2 shall resolve independently; a one-cycle intermediate output pattern is permitted when setup is violated on only one input.
REQ-015 Truth table at output: 00->out1=0,out2=0; 01->0,1; 10->0,1; 11->1,1.
REQ-016 When counting is enabled, chg_cnt shall increment by 1 on each cycle where s differs from its previous-cycle value; a two-bit change counts once.
REQ-017 chg_cnt shall saturate at 2^CNT_W-1 and shall not wrap.
REQ-018 The first s value after reset shall not count as a change.

Reset
REQ-019 rst_n low shall immediately clear all synchronizer flops, out1, out2 and chg_cnt to 0, regardless of clk.
REQ-020 Deassertion shall be synchronized internally through a 2-flop reset synchronizer; outputs resume tracking inputs SYNC_STAGES+1 edges after the synchronized release.
REQ-021 Reset asserted mid-operation shall discard all in-flight synchronizer data.

Configuration
REQ-022 With macro FIRST_SYSTEM_CNT_EN defined, the chg_cnt port and the counter logic shall be compiled in.
REQ-023 Without FIRST_SYSTEM_CNT_EN, chg_cnt and its logic shall be absent; out1/out2 behaviour shall be identical in both builds.

Structure
REQ-024 A shared package first_system_pkg shall hold the SYNC_STAGES and CNT_W defaults and the truth-table constants used by the bench model.
REQ-025 The synchronizer chain shall be one sub-module, fs_sync, instantiated once per input and once for the reset release.

Verification
REQ-026 Reset: rst_n=0 with in1=in2=1 -> out1=0, out2=0, chg_cnt=0 immediately, before any clock edge.
REQ-027 Walk: apply {in1,in2} = 00,01,10,11,00, each held 10 cycles -> (out1,out2) = 00,01,01,11,00, each appearing exactly 3 edges after the input change; chg_cnt=4.
REQ-028 Simultaneous: 00->11 with both inputs changed on the same edge -> out1=1, out2=1 after 3 edges; chg_cnt increments by 1.
REQ-029 Saturation with CNT_W=2: toggle in1 six times, each level held 5 cycles -> chg_cnt reaches 3 and holds 3.
REQ-030 Reset mid-flight: change in1 0->1, assert rst_n one edge later, release -> out2 stays 0 until the next sampled change; no spurious count.
REQ-031 Build without FIRST_SYSTEM_CNT_EN: rerun REQ-027 -> identical out1/out2 traces; no chg_cnt port.
